// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: takes DATA_BITS data bits LSB first, then one parity bit.
// It reports the assembled word, the parity verdict, a saturating error count and an inter-bit timeout.
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   IDLE   | no frame in progress; only START is honoured
//   DATA   | collecting data bits into shift, folding them into acc
//   PARITY | waiting for the parity bit that closes the frame
module parity_frame_checker #(
    parameter int DATA_BITS = 8,
    parameter int ODD       = 0,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 BIT_IN,
    input  logic                 BIT_VALID,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PAR_OK,
    output logic                 PAR_ERR,
    output logic                 TMO,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic [CNT_W-1:0]     ERR_CNT
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    localparam int BC_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam int TC_W = $clog2(TIMEOUT + 1);

    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);
    localparam logic [TC_W-1:0] TMO_LAST = TC_W'(TIMEOUT - 1);
    localparam logic            ACC_INIT = (ODD != 0);

    logic [1:0]           state;
    logic                 acc;
    logic [BC_W-1:0]      bitcnt;
    logic [DATA_BITS-1:0] shift;
    logic [TC_W-1:0]      tmo_cnt;
    logic                 err;
    logic                 timeout_hit;

    assign err = acc ^ BIT_IN;

    // The idle cycle being sampled now is the TIMEOUT-th in a row.
    assign timeout_hit = (state != IDLE) && !BIT_VALID && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PAR_OK   <= 1'b0;
            PAR_ERR  <= 1'b0;
            TMO      <= 1'b0;
            DATA_OUT <= '0;
            ERR_CNT  <= '0;
            acc      <= 1'b0;
            bitcnt   <= '0;
            shift    <= '0;
            tmo_cnt  <= '0;
        end else begin
            DONE <= 1'b0;
            TMO  <= 1'b0;
            if (START) begin
                // Restart beats both a same-cycle bit and a same-cycle timeout.
                state   <= DATA;
                BUSY    <= 1'b1;
                acc     <= ACC_INIT;
                bitcnt  <= '0;
                tmo_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        BUSY <= 1'b0;
                    end
                    DATA: begin
                        if (BIT_VALID) begin
                            acc           <= acc ^ BIT_IN;
                            shift[bitcnt] <= BIT_IN;
                            tmo_cnt       <= '0;
                            if (bitcnt == LAST_BIT) begin
                                state <= PARITY;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end else if (timeout_hit) begin
                            state   <= IDLE;
                            BUSY    <= 1'b0;
                            TMO     <= 1'b1;
                            tmo_cnt <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (BIT_VALID) begin
                            DONE     <= 1'b1;
                            PAR_OK   <= ~err;
                            PAR_ERR  <= err;
                            DATA_OUT <= shift;
                            if (err && (ERR_CNT != '1)) begin
                                ERR_CNT <= ERR_CNT + 1'b1;
                            end
                            state   <= IDLE;
                            BUSY    <= 1'b0;
                            tmo_cnt <= '0;
                        end else if (timeout_hit) begin
                            state   <= IDLE;
                            BUSY    <= 1'b0;
                            TMO     <= 1'b1;
                            tmo_cnt <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: an even-parity/short-timeout/2-bit-count instance and an odd-parity instance share one stimulus.
// Both instances are compared every cycle against a frame-level model, with literal expectations at key points.
module tb_parity_frame_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;

    logic       e_busy, e_done, e_ok, e_err, e_tmo;
    logic [7:0] e_data;
    logic [1:0] e_cnt;
    logic       o_busy, o_done, o_ok, o_err, o_tmo;
    logic [7:0] o_data;
    logic [7:0] o_cnt;

    int total = 0;
    int bad = 0;
    int done_cnt_e = 0;

    parity_frame_checker #(.DATA_BITS(8), .ODD(0), .CNT_W(2), .TIMEOUT(4)) dut_e (
        .CLK(clk), .RST_N(rst_n), .START(start), .BIT_IN(bit_in), .BIT_VALID(bit_valid),
        .BUSY(e_busy), .DONE(e_done), .PAR_OK(e_ok), .PAR_ERR(e_err), .TMO(e_tmo),
        .DATA_OUT(e_data), .ERR_CNT(e_cnt)
    );

    parity_frame_checker #(.DATA_BITS(8), .ODD(1), .CNT_W(8), .TIMEOUT(16)) dut_o (
        .CLK(clk), .RST_N(rst_n), .START(start), .BIT_IN(bit_in), .BIT_VALID(bit_valid),
        .BUSY(o_busy), .DONE(o_done), .PAR_OK(o_ok), .PAR_ERR(o_err), .TMO(o_tmo),
        .DATA_OUT(o_data), .ERR_CNT(o_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: index 0 = even instance, index 1 = odd instance.
    int       m_busy[2], m_done[2], m_tmo[2], m_ok[2], m_err[2], m_data[2], m_cnt[2];
    int       m_n[2], m_idle[2];
    bit [7:0] m_bits[2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            int odd, to, cmax, ones;
            odd  = (i == 1) ? 1 : 0;
            to   = (i == 0) ? 4 : 16;
            cmax = (i == 0) ? 3 : 255;
            if (!rst_n) begin
                m_busy[i] = 0; m_done[i] = 0; m_tmo[i] = 0; m_ok[i] = 0; m_err[i] = 0;
                m_data[i] = 0; m_cnt[i] = 0; m_n[i] = 0; m_idle[i] = 0; m_bits[i] = 8'h00;
            end else begin
                m_done[i] = 0;
                m_tmo[i]  = 0;
                if (start) begin
                    m_busy[i] = 1; m_n[i] = 0; m_idle[i] = 0; m_bits[i] = 8'h00;
                end else if (m_busy[i] != 0) begin
                    if (bit_valid) begin
                        m_idle[i] = 0;
                        if (m_n[i] < 8) begin
                            m_bits[i][m_n[i]] = bit_in;
                            m_n[i]++;
                        end else begin
                            ones = $countones(m_bits[i]) + int'(bit_in);
                            m_err[i]  = ((ones % 2) != odd) ? 1 : 0;
                            m_ok[i]   = 1 - m_err[i];
                            m_data[i] = int'(m_bits[i]);
                            if (m_err[i] != 0 && m_cnt[i] < cmax) m_cnt[i]++;
                            m_done[i] = 1;
                            m_busy[i] = 0;
                        end
                    end else begin
                        m_idle[i]++;
                        if (m_idle[i] == to) begin
                            m_tmo[i]  = 1;
                            m_busy[i] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (e_done === 1'b1) done_cnt_e++;
        chk("e.busy", e_busy, m_busy[0]);
        chk("e.done", e_done, m_done[0]);
        chk("e.par_ok", e_ok, m_ok[0]);
        chk("e.par_err", e_err, m_err[0]);
        chk("e.tmo", e_tmo, m_tmo[0]);
        chk("e.data", e_data, m_data[0]);
        chk("e.err_cnt", e_cnt, m_cnt[0]);
        chk("o.busy", o_busy, m_busy[1]);
        chk("o.done", o_done, m_done[1]);
        chk("o.par_ok", o_ok, m_ok[1]);
        chk("o.par_err", o_err, m_err[1]);
        chk("o.tmo", o_tmo, m_tmo[1]);
        chk("o.data", o_data, m_data[1]);
        chk("o.err_cnt", o_cnt, m_cnt[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            bit_valid = 1'b1;
            bit_in    = d[k];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    // START carries a valid '1' bit alongside it, which must be discarded.
    task automatic send_start();
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        logic [7:0] pv;
        pv = {7'b0, p};
        send_start();
        send_bits(d, 8);
        send_bits(pv, 1);
    endtask

    initial begin
        int base;
        repeat (3) tick();
        chk("rst.busy", e_busy, 0);
        chk("rst.data", e_data, 0);
        chk("rst.cnt", e_cnt, 0);
        rst_n = 1'b1;
        tick();

        send_frame(8'hA5, 1'b0);
        chk("a5p0.done", e_done, 1);
        chk("a5p0.ok", e_ok, 1);
        chk("a5p0.err", e_err, 0);
        chk("a5p0.data", e_data, 8'hA5);
        chk("a5p0.cnt", e_cnt, 0);
        chk("a5p0.odd_err", o_err, 1);
        tick();
        chk("a5p0.done_pulse", e_done, 0);

        send_frame(8'hA5, 1'b1);
        chk("a5p1.err", e_err, 1);
        chk("a5p1.ok", e_ok, 0);
        chk("a5p1.cnt", e_cnt, 1);
        send_frame(8'h01, 1'b1);
        chk("01p1.ok", e_ok, 1);
        chk("01p1.cnt", e_cnt, 1);
        chk("01p1.data", e_data, 8'h01);

        send_frame(8'h00, 1'b1);
        chk("odd00p1.ok", o_ok, 1);
        chk("even00p1.cnt", e_cnt, 2);
        send_frame(8'h00, 1'b0);
        chk("odd00p0.err", o_err, 1);
        chk("odd00p0.cnt", o_cnt, 3);

        send_start();
        send_bits(8'h07, 3);
        repeat (3) tick();
        chk("tmo.early", e_tmo, 0);
        chk("tmo.still_busy", e_busy, 1);
        tick();
        chk("tmo.pulse", e_tmo, 1);
        chk("tmo.busy", e_busy, 0);
        chk("tmo.no_done", e_done, 0);
        chk("tmo.data", e_data, 8'h00);
        chk("tmo.cnt", e_cnt, 2);
        tick();
        chk("tmo.pulse_end", e_tmo, 0);
        repeat (16) tick();
        chk("tmo.odd_idle", o_busy, 0);

        base = done_cnt_e;
        send_start();
        send_bits(8'hFF, 5);
        send_start();
        send_bits(8'h5B, 8);
        send_frame(8'h3C, 1'b0);
        chk("restart.data", e_data, 8'h3C);
        chk("restart.ok", e_ok, 1);
        tick();
        chk("restart.one_done", done_cnt_e - base, 1);

        for (int k = 0; k < 3; k++) send_frame(8'hA5, 1'b1);
        chk("sat.cnt", e_cnt, 3);

        send_start();
        send_bits(8'h0F, 4);
        rst_n = 1'b0;
        #1;
        chk("midrst.cnt", e_cnt, 0);
        chk("midrst.busy", e_busy, 0);
        chk("midrst.data", e_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'h5A, 1'b0);
        chk("post_rst.done", e_done, 1);
        chk("post_rst.data", e_data, 8'h5A);
        chk("post_rst.ok", e_ok, 1);

        send_frame(8'hFF, 1'b0);
        chk("b2b1.ok", e_ok, 1);
        send_frame(8'h80, 1'b1);
        chk("b2b2.ok", e_ok, 1);
        chk("b2b2.data", e_data, 8'h80);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
